// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, oversampling ratio and frame-length helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Ticks from accept to tx_done for one frame.
  function automatic int frame_ticks(input int dbit, input int sb_tick);
    return OVERSAMPLE * (dbit + 1) + sb_tick;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one frame per accepted word (start, DBIT data bits LSB-first, stop),
// paced by a shared oversampling tick.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            tx_valid,
  input  logic [DBIT-1:0] tx_data,
  output logic            tx_ready,
  output logic            tx_busy,
  output logic            tx_done,
  output logic            tx
);

  localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int SW    = $clog2(S_MAX);
  localparam int NW    = $clog2(DBIT);

  localparam logic [SW-1:0] OS_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  tx_state_t       state, state_nxt;
  logic [SW-1:0]   s_cnt, s_nxt;
  logic [NW-1:0]   n_cnt, n_nxt;
  logic [DBIT-1:0] shreg, sh_nxt;
  logic            tx_reg, tx_nxt;
  logic            done_reg, done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      s_cnt    <= '0;
      n_cnt    <= '0;
      shreg    <= '0;
      tx_reg   <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      state    <= state_nxt;
      s_cnt    <= s_nxt;
      n_cnt    <= n_nxt;
      shreg    <= sh_nxt;
      tx_reg   <= tx_nxt;
      done_reg <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s_cnt;
    n_nxt     = n_cnt;
    sh_nxt    = shreg;
    tx_nxt    = tx_reg;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // A tick coinciding with accept is deliberately not counted.
        if (tx_valid) begin
          sh_nxt    = tx_data;
          s_nxt     = '0;
          n_nxt     = '0;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == OS_LAST) begin
            s_nxt     = '0;
            tx_nxt    = shreg[0];
            state_nxt = DATA;
          end else begin
            s_nxt = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == OS_LAST) begin
            s_nxt  = '0;
            sh_nxt = {1'b0, shreg[DBIT-1:1]};
            if (n_cnt == N_LAST) begin
              tx_nxt    = 1'b1;
              state_nxt = STOP;
            end else begin
              n_nxt  = n_cnt + 1'b1;
              tx_nxt = shreg[1];
            end
          end else begin
            s_nxt = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == SB_LAST) begin
            s_nxt     = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            s_nxt = s_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_ready = (state == IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx_done  = done_reg;
  assign tx       = tx_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: an 8N1 instance and a 7-bit / 2-stop instance,
// each decoded by a tick-counting line monitor.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tick0, s_tick1;
  logic       tx_valid0, tx_valid1;
  logic [7:0] tx_data0;
  logic [6:0] tx_data1;
  logic       tx_ready0, tx_busy0, tx_done0, tx0;
  logic       tx_ready1, tx_busy1, tx_done1, tx1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int tick_per0 = 0, tick_per1 = 0;
  int tick_ph0  = 0, tick_ph1  = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit         mact[2];
  int         mcnt[2];
  logic [8:0] mexp[2];
  int         done_cyc[2];
  int         prev_done[2];
  bit         pa0, pt0, pa1, pt1;

  uart_tx_ctrl #(.DBIT(8), .SB_TICK(16)) dut0 (
    .clk(clk), .rst(rst), .s_tick(s_tick0), .tx_valid(tx_valid0), .tx_data(tx_data0),
    .tx_ready(tx_ready0), .tx_busy(tx_busy0), .tx_done(tx_done0), .tx(tx0)
  );

  uart_tx_ctrl #(.DBIT(7), .SB_TICK(32)) dut1 (
    .clk(clk), .rst(rst), .s_tick(s_tick1), .tx_valid(tx_valid1), .tx_data(tx_data1),
    .tx_ready(tx_ready1), .tx_busy(tx_busy1), .tx_done(tx_done1), .tx(tx1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (tick_per0 == 0) s_tick0 = 1'b0;
    else begin
      tick_ph0 = (tick_ph0 + 1) % tick_per0;
      s_tick0  = (tick_ph0 == 0);
    end
    if (tick_per1 == 0) s_tick1 = 1'b0;
    else begin
      tick_ph1 = (tick_ph1 + 1) % tick_per1;
      s_tick1  = (tick_ph1 == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  // acc/tick describe the clock edge just passed; outputs are sampled now.
  task automatic mon_step(input int idx, input bit acc, input bit tick, input bit r,
                          input logic txv, input logic donev, input logic readyv,
                          input logic busyv);
    int   db, sb, total, seg;
    logic etx, edone;
    db    = (idx == 0) ? 8 : 7;
    sb    = (idx == 0) ? 16 : 32;
    total = 16 * (db + 1) + sb;
    edone = 1'b0;
    if (r) begin
      mact[idx] = 1'b0;
      if (idx == 0) q0.delete(); else q1.delete();
      chk("rst_tx", {31'd0, txv}, 32'd1);
      chk("rst_done", {31'd0, donev}, 32'd0);
      chk("rst_ready", {31'd0, readyv}, 32'd1);
      chk("rst_busy", {31'd0, busyv}, 32'd0);
      return;
    end
    if (acc) begin
      if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
        chk("unexpected_accept", 32'd1, 32'd0);
        mexp[idx] = '0;
      end else if (idx == 0) mexp[idx] = q0.pop_front();
      else mexp[idx] = q1.pop_front();
      mact[idx] = 1'b1;
      mcnt[idx] = 0;
    end else if (mact[idx] && tick) begin
      mcnt[idx]++;
    end
    if (mact[idx]) begin
      seg = mcnt[idx] / 16;
      if (seg == 0) etx = 1'b0;
      else if (seg <= db) etx = mexp[idx][seg-1];
      else etx = 1'b1;
      chk(idx == 0 ? "frame_tx0" : "frame_tx1", {31'd0, txv}, {31'd0, etx});
      if (mcnt[idx] == total) begin
        edone          = 1'b1;
        mact[idx]      = 1'b0;
        prev_done[idx] = done_cyc[idx];
        done_cyc[idx]  = cyc;
      end
    end else begin
      chk(idx == 0 ? "idle_tx0" : "idle_tx1", {31'd0, txv}, 32'd1);
    end
    chk(idx == 0 ? "done0" : "done1", {31'd0, donev}, {31'd0, edone});
    chk(idx == 0 ? "ready0" : "ready1", {31'd0, readyv}, {31'd0, !mact[idx]});
    chk(idx == 0 ? "busy0" : "busy1", {31'd0, busyv}, {31'd0, mact[idx]});
  endtask

  always @(negedge clk) begin
    mon_step(0, pa0, pt0, rst, tx0, tx_done0, tx_ready0, tx_busy0);
    mon_step(1, pa1, pt1, rst, tx1, tx_done1, tx_ready1, tx_busy1);
    pa0 = tx_valid0 && tx_ready0 && !rst;
    pt0 = s_tick0;
    pa1 = tx_valid1 && tx_ready1 && !rst;
    pt1 = s_tick1;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int idx, input logic [8:0] d, input bit keep);
    bit ok;
    ok = 1'b0;
    if (idx == 0) begin
      tx_data0  = d[7:0];
      tx_valid0 = 1'b1;
      q0.push_back(d);
    end else begin
      tx_data1  = d[6:0];
      tx_valid1 = 1'b1;
      q1.push_back(d);
    end
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ((idx == 0) ? tx_ready0 : tx_ready1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      if (idx == 0) tx_valid0 = 1'b0; else tx_valid1 = 1'b0;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int idx);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!mact[idx] && ((idx == 0) ? q0.size() == 0 : q1.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    rst       = 1'b1;
    s_tick0   = 1'b0;
    s_tick1   = 1'b0;
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;
    tx_data0  = '0;
    tx_data1  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx0", {31'd0, tx0}, 32'd1);
    chk("reset_ready0", {31'd0, tx_ready0}, 32'd1);
    chk("reset_tx1", {31'd0, tx1}, 32'd1);
    chk("reset_done1", {31'd0, tx_done1}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // basic 8N1 frame, tick every 4 clk
    tick_per0 = 4;
    send(0, 9'h0A5, 1'b0);
    wait_idle(0);

    // busy rejection: 0x3C offered mid-frame must not disturb 0xA5
    send(0, 9'h0A5, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tx_valid0 = 1'b1;
      tx_data0  = 8'h3C;
      @(posedge clk);
      #1;
    end
    tx_valid0 = 1'b0;
    chk("busy_during_reject", {31'd0, tx_busy0}, 32'd1);
    send(0, 9'h03C, 1'b0);
    wait_idle(0);

    // back-to-back with tick every clk
    tick_per0 = 1;
    send(0, 9'h000, 1'b1);
    send(0, 9'h0FF, 1'b0);
    wait_idle(0);
    chk("b2b_done_gap", done_cyc[0] - prev_done[0], 32'd161);

    // reset during data bit 3
    tick_per0 = 4;
    send(0, 9'h0A5, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (mcnt[0] >= 68) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("reach_bit3_timeout", 32'd0, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", {31'd0, tx0}, 32'd1);
    chk("async_rst_ready", {31'd0, tx_ready0}, 32'd1);
    chk("async_rst_done", {31'd0, tx_done0}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, 9'h055, 1'b0);
    wait_idle(0);

    // 7 data bits, 2 stop bits, tick every 2 clk
    tick_per1 = 2;
    send(1, 9'h07F, 1'b0);
    wait_idle(1);

    // no ticks: frame parks in the start bit
    tick_per0 = 0;
    send(0, 9'h012, 1'b0);
    repeat (500) @(posedge clk);
    #1;
    chk("notick_tx", {31'd0, tx0}, 32'd0);
    chk("notick_busy", {31'd0, tx_busy0}, 32'd1);
    tick_per0 = 3;
    wait_idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
